fetch_unit: RTL and testbench

- Instruction-fetch stage that owns the 32-bit PC and drives the IF/ID pipeline register consumed by decode.
- Decode reads the 16-bit instruction, its PC and an immediate-word tag from this block.
- Decode and the control unit drive this block back through pc_sel, pc_jmp, the pop strobes and the stall/enable controls.
- Boots by reading the start PC from instruction memory words 0 and 1. Handles jump and popped-PC redirects with a one-slot flush.

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, decode/control feedback and IF/ID outputs.
// No added latency; just groups the signals.
// No backpressure here; stall/fetch_pc_enable/pc_sel carry the hold controls.
interface fetch_unit_if #(
   parameter int WIDTH    = 16,
   parameter int PC_WIDTH = 32
);
   logic [PC_WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0]    imem_data;
   logic                stall;
   logic                fetch_pc_enable;
   logic [1:0]          pc_sel;
   logic [PC_WIDTH-1:0] pc_jmp;
   logic                pop_pc1;
   logic                pop_pc2;
   logic [WIDTH-1:0]    pop_data;
   logic [WIDTH-1:0]    instruction;
   logic [PC_WIDTH-1:0] if_pc;
   logic [PC_WIDTH-1:0] pc;
   logic                valid;
   logic                imm_word;

   // Fetch unit side
   modport master (
      output imem_addr, instruction, if_pc, pc, valid, imm_word,
      input  imem_data, stall, fetch_pc_enable, pc_sel, pc_jmp,
             pop_pc1, pop_pc2, pop_data
   );

   // Memory / decode / control side
   modport slave (
      input  imem_addr, instruction, if_pc, pc, valid, imm_word,
      output imem_data, stall, fetch_pc_enable, pc_sel, pc_jmp,
             pop_pc1, pop_pc2, pop_data
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, boots it from memory words 0/1, drives IF/ID.
// Latency: word at address A appears on instruction one cycle after pc=A.
// Backpressure: stall, ~fetch_pc_enable or pc_sel=11 freeze PC and IF/ID; redirects still win.
module fetch_unit #(
   parameter int         WIDTH     = 16,
   parameter int         PC_WIDTH  = 32,
   parameter logic [2:0] IMM_CLASS = 3'b011
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      BOOT_HI = 2'd0,
      BOOT_LO = 2'd1,
      RUN     = 2'd2
   } state_t;

   state_t              state;
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] if_pc_q;
   logic [WIDTH-1:0]    instruction_q;
   logic [WIDTH-1:0]    pop_hi;
   logic [WIDTH-1:0]    pop_lo;
   logic                valid_q;
   logic                imm_word_q;
   logic                imm_pending;
   logic                hold;

   assign hold = bus.stall | ~bus.fetch_pc_enable;

   assign bus.pc          = pc_q;
   assign bus.if_pc       = if_pc_q;
   assign bus.instruction = instruction_q;
   assign bus.valid       = valid_q;
   assign bus.imm_word    = imm_word_q;

   // Memory address: the two boot words first, then the running PC.
   always_comb begin
      bus.imem_addr = pc_q;
      case (state)
         BOOT_HI: bus.imem_addr = '0;
         BOOT_LO: bus.imem_addr = PC_WIDTH'(1);
         default: bus.imem_addr = pc_q;
      endcase
   end

   // Boot sequencing, PC update, pop capture and the IF/ID register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= BOOT_HI;
         pc_q          <= '0;
         pop_hi        <= '0;
         pop_lo        <= '0;
         imm_pending   <= 1'b0;
         instruction_q <= '0;
         if_pc_q       <= '0;
         valid_q       <= 1'b0;
         imm_word_q    <= 1'b0;
      end else begin
         case (state)
            BOOT_HI: begin
               pc_q[PC_WIDTH-1:WIDTH] <= bus.imem_data;
               state                  <= BOOT_LO;
            end
            BOOT_LO: begin
               pc_q[WIDTH-1:0] <= bus.imem_data;
               state           <= RUN;
            end
            default: begin
               // Pop registers load independently; a redirect this cycle
               // uses the values captured in earlier cycles.
               if (bus.pop_pc1) pop_hi <= bus.pop_data;
               if (bus.pop_pc2) pop_lo <= bus.pop_data;

               if (bus.pc_sel == 2'b01 || bus.pc_sel == 2'b10) begin
                  // Redirect: new PC and flush the wrong-path slot.
                  pc_q          <= (bus.pc_sel == 2'b01) ? bus.pc_jmp : {pop_hi, pop_lo};
                  instruction_q <= '0;
                  valid_q       <= 1'b0;
                  imm_word_q    <= 1'b0;
                  imm_pending   <= 1'b0;
               end else if (!hold && bus.pc_sel == 2'b00) begin
                  instruction_q <= bus.imem_data;
                  if_pc_q       <= pc_q;
                  valid_q       <= 1'b1;
                  pc_q          <= pc_q + PC_WIDTH'(1);
                  // The immediate word itself never arms a new tag, so an
                  // immediate that looks like a two-word opcode is harmless.
                  if (imm_pending) begin
                     imm_word_q  <= 1'b1;
                     imm_pending <= 1'b0;
                  end else begin
                     imm_word_q  <= 1'b0;
                     imm_pending <= (bus.imem_data[WIDTH-1:WIDTH-3] == IMM_CLASS);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic
// compared every cycle against a behavioural model of the fetch stage.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fetch_unit_if bus ();

   fetch_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Combinational instruction memory, 256 words aliased over the address space.
   logic [15:0] mem [256];
   assign bus.imem_data = mem[bus.imem_addr[7:0]];

   // Reference model state.
   int          m_boot;      // boot words still to read (2, 1, 0 = running)
   logic [31:0] m_pc;
   logic [31:0] m_if_pc;
   logic [15:0] m_instr;
   logic        m_valid;
   logic        m_imm;
   logic        m_pending;
   logic [15:0] m_pop_hi;
   logic [15:0] m_pop_lo;

   function automatic logic [31:0] model_addr();
      if (m_boot == 2) return 32'd0;
      if (m_boot == 1) return 32'd1;
      return m_pc;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=0x%08h expected=0x%08h @%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("imem_addr",   bus.imem_addr,          model_addr());
      check("pc",          bus.pc,                 m_pc);
      check("instruction", {16'h0, bus.instruction}, {16'h0, m_instr});
      check("if_pc",       bus.if_pc,              m_if_pc);
      check("valid",       {31'h0, bus.valid},     {31'h0, m_valid});
      check("imm_word",    {31'h0, bus.imm_word},  {31'h0, m_imm});
   endtask

   // Advance the model by one clock edge from the given inputs.
   task automatic model_step(input logic r, input logic s, input logic e, input logic [1:0] sel,
                             input logic [31:0] j, input logic p1, input logic p2,
                             input logic [15:0] pd);
      logic [15:0] word;
      word = mem[model_addr() & 32'hFF];
      if (r) begin
         m_boot = 2; m_pc = 0; m_if_pc = 0; m_instr = 0; m_valid = 0;
         m_imm = 0; m_pending = 0; m_pop_hi = 0; m_pop_lo = 0;
      end else if (m_boot == 2) begin
         m_pc = {word, 16'h0};
         m_boot = 1;
      end else if (m_boot == 1) begin
         m_pc = {m_pc[31:16], word};
         m_boot = 0;
      end else begin
         logic [31:0] target;
         target = {m_pop_hi, m_pop_lo};
         if (p1) m_pop_hi = pd;
         if (p2) m_pop_lo = pd;
         if (sel == 2'b01 || sel == 2'b10) begin
            m_pc = (sel == 2'b01) ? j : target;
            m_instr = 0; m_valid = 0; m_imm = 0; m_pending = 0;
         end else if (sel == 2'b00 && !s && e) begin
            m_instr = word;
            m_if_pc = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 1;
            m_imm   = m_pending;
            m_pending = !m_pending && (word[15:13] == 3'b011);
         end
      end
   endtask

   // Apply one cycle of inputs, clock it, then compare everything on the falling edge.
   task automatic drive(input logic r, input logic s, input logic e, input logic [1:0] sel,
                        input logic [31:0] j, input logic p1, input logic p2,
                        input logic [15:0] pd);
      rst                 = r;
      bus.stall           = s;
      bus.fetch_pc_enable = e;
      bus.pc_sel          = sel;
      bus.pc_jmp          = j;
      bus.pop_pc1         = p1;
      bus.pop_pc2         = p2;
      bus.pop_data        = pd;
      model_step(r, s, e, sel, j, p1, p2, pd);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic seq();
      drive(0, 0, 1, 2'b00, 32'h0, 0, 0, 16'h0);
   endtask

   task automatic jump(input logic [31:0] t);
      drive(0, 0, 1, 2'b01, t, 0, 0, 16'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[8'h00] = 16'h0000;
      mem[8'h01] = 16'h0020;
      mem[8'h20] = 16'h0800;
      mem[8'h21] = 16'h1111;
      mem[8'h22] = 16'h2222;
      mem[8'h23] = 16'h3333;
      mem[8'h40] = 16'h6000;
      mem[8'h41] = 16'h6000;
      mem[8'h42] = 16'h1234;
      mem[8'h50] = 16'h6000;
      mem[8'h60] = 16'h0800;

      rst = 1'b1;
      bus.stall = 0; bus.fetch_pc_enable = 1; bus.pc_sel = 0; bus.pc_jmp = 0;
      bus.pop_pc1 = 0; bus.pop_pc2 = 0; bus.pop_data = 0;
      @(negedge clk);

      // Reset state.
      drive(1, 0, 1, 2'b00, 32'h0, 0, 0, 16'h0);
      check("rst_valid", {31'h0, bus.valid}, 32'd0);
      check("rst_addr", bus.imem_addr, 32'd0);

      // Boot: controls are ignored while the start PC is read.
      drive(0, 1, 0, 2'b01, 32'h1234, 0, 0, 16'h0);
      check("boot1_addr", bus.imem_addr, 32'd1);
      drive(0, 1, 0, 2'b11, 32'h1234, 0, 0, 16'h0);
      check("boot_pc", bus.pc, 32'h20);
      check("boot_valid", {31'h0, bus.valid}, 32'd0);
      seq();
      check("first_instr", {16'h0, bus.instruction}, 32'h0800);
      check("first_if_pc", bus.if_pc, 32'h20);
      check("first_valid", {31'h0, bus.valid}, 32'd1);

      // Stall two cycles at pc=0x22, then resume without loss or duplication.
      seq();
      drive(0, 1, 1, 2'b00, 32'h0, 0, 0, 16'h0);
      drive(0, 0, 0, 2'b00, 32'h0, 0, 0, 16'h0);
      check("stall_pc", bus.pc, 32'h22);
      check("stall_if_pc", bus.if_pc, 32'h21);
      seq();
      check("resume_if_pc", bus.if_pc, 32'h22);
      check("resume_instr", {16'h0, bus.instruction}, 32'h2222);

      // Jump taken under stall flushes the slot.
      drive(0, 1, 1, 2'b01, 32'h100, 0, 0, 16'h0);
      check("jmp_pc", bus.pc, 32'h100);
      check("jmp_flush", {15'h0, bus.valid, bus.instruction}, 32'd0);
      seq();
      check("jmp_if_pc", bus.if_pc, 32'h100);
      check("jmp_valid", {31'h0, bus.valid}, 32'd1);

      // Popped PC redirect.
      drive(0, 0, 1, 2'b11, 32'h0, 1, 0, 16'h0001);
      drive(0, 0, 1, 2'b11, 32'h0, 0, 1, 16'h0040);
      drive(0, 0, 1, 2'b10, 32'h0, 0, 0, 16'h0);
      check("pop_pc", bus.pc, 32'h0001_0040);
      check("pop_flush", {31'h0, bus.valid}, 32'd0);

      // Two-word instruction followed by a look-alike immediate.
      jump(32'h40);
      seq();
      check("imm_first", {31'h0, bus.imm_word}, 32'd0);
      seq();
      check("imm_tag", {31'h0, bus.imm_word}, 32'd1);
      seq();
      check("imm_after", {31'h0, bus.imm_word}, 32'd0);

      // A redirect between the two words drops the pending tag.
      jump(32'h50);
      seq();
      jump(32'h60);
      seq();
      check("imm_cleared", {31'h0, bus.imm_word}, 32'd0);

      // PC wraps at the top of the address space.
      jump(32'hFFFF_FFFF);
      seq();
      check("wrap_pc", bus.pc, 32'h0);
      check("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFF);

      // Reset in the middle of a run.
      drive(1, 0, 1, 2'b01, 32'h77, 1, 1, 16'hBEEF);
      check("midrst_addr", bus.imem_addr, 32'd0);
      check("midrst_valid", {31'h0, bus.valid}, 32'd0);
      check("midrst_instr", {16'h0, bus.instruction}, 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         logic [1:0]  sel;
         logic [31:0] tgt;
         int          pick;
         pick = $urandom_range(0, 15);
         sel  = (pick < 10) ? 2'b00 : (pick < 12) ? 2'b01 : (pick < 14) ? 2'b10 : 2'b11;
         tgt  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
         drive(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 7) != 0),
               sel, tgt,
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) == 0),
               16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
